avr_fetch_ctrl: RTL and testbench
=================================

Name: avr_fetch_ctrl

Overview:
Instruction fetch sequencer for avr_cpu. Owns the program counter and drives a synchronous program ROM. Delivers one 16-bit instruction word per cycle on instr/instr_valid, gathers the second word of 32-bit opcodes into op2, and performs jumps, relative jumps and skips with a fixed 2-cycle bubble. Sits between the pmem ROM and the CPU's instr input.

Parameters:
PC_W, 9, program-counter / word-address width (512-word pmem)
RST_VEC, 0, word address of the first instruction after reset

Ports:
CLK  in  1  clock, all state changes on rising edge
RST  in  1  asynchronous, active-high reset
pm_addr  out  PC_W  ROM word address (registered)
pm_en  out  1  ROM read enable (combinational); ROM updates pm_data only on edges where pm_en=1, otherwise holds
pm_data  in  16  ROM data, = mem[pm_addr] one cycle after pm_en
instr  out  16  current instruction word (first word)
op2  out  16  second word of 2-word instruction, else 0
instr_valid  out  1  instr/op2/pc valid for execution this cycle
pc  out  PC_W  word address of instr
stall  in  1  CPU hold request; freezes the whole sequencer
jmp_req  in  1  absolute redirect to jmp_target
jmp_target  in  PC_W  absolute word address
rjmp_req  in  1  relative redirect
rjmp_off  in  12  signed word offset (k)
skip_req  in  1  skip next instruction (size-aware)

Behaviour:
- Reset (async): pm_addr=RST_VEC, pc=RST_VEC, instr=0 (NOP), op2=0, instr_valid=0, state=FILL0. pm_en=0 while RST=1.
- pm_en = !RST & !stall. When stall=1, no register changes (state, pc, pm_addr, instr, op2, instr_valid) and ROM output held.
- States: FILL0, FILL1, RUN, WORD2. pm_addr += 1 (mod 2^PC_W) on every non-stalled edge except redirect edges.
- FILL0: pm_data stale/don't-care; instr_valid=0; -> FILL1.
- FILL1: pm_data = mem[fill addr]; instr_valid=0. On edge: instr<=pm_data, pc<=fill addr, op2<=0; -> WORD2 if pm_data is 2-word, else RUN.
- RUN: instr_valid=1. On edge, if no redirect, capture the next word as in FILL1 with pc<=pc+len(current).
- WORD2: instr_valid=0, pm_data = second word. On edge: op2<=pm_data; -> RUN (instr and pc unchanged).
- 2-word decode (on captured word w): LDS w[15:9]=1001000 & w[3:0]=0000; STS w[15:9]=1001001 & w[3:0]=0000; JMP/CALL w[15:9]=1001010 & w[3:1]=110/111.
- len = 2 if instr is 2-word, else 1. npc = pc + len.
- Redirects are sampled only in RUN with instr_valid=1 and stall=0. Priority: jmp > rjmp > skip; the lower-priority requests are ignored.
  - jmp: target = jmp_target.
  - rjmp: target = npc + sext(rjmp_off), mod 2^PC_W.
  - skip: target = npc + 1 + is2word(pm_data). pm_data holds mem[npc] in RUN.
- On a redirect edge: pm_addr<=target, instr_valid<=0, state<=FILL0. The first valid instruction is mem[target], 3 cycles after the redirect cycle, leaving exactly 2 bubble cycles.
- Redirects in FILL0, FILL1 or WORD2 are ignored; the CPU must not issue them there.
- Wrap-around: pm_addr and target arithmetic wrap modulo 2^PC_W; no error flag.
- RST asserted mid-operation (including during WORD2 or a stall): immediate return to reset values; the refetch from RST_VEC follows the FILL0/FILL1 timing after release.

Decomposition:
- Shared package avr_pkg: state encoding, PC_W default, 2-word opcode masks/match constants, NOP constant.
- One sub-module avr_insn_len: combinational 16-bit word -> is2word. Reused by CPU decode.

Test Plan:
- Reset/boot: mem[0..2]=E0A4,50A1,0000; RST pulse -> instr_valid rises on 3rd cycle after release with instr=E0A4, pc=0; then 50A1 (pc=1) and 0000 (pc=2) on consecutive cycles.
- 2-word: mem[4]=9100 (LDS), mem[5]=0060, mem[6]=0F01 -> instr=9100 with op2=0060, pc=4, valid after one invalid WORD2 cycle; next instr=0F01, pc=6, op2=0.
- jmp_req with jmp_target=0x1F0 at pc=6 -> exactly 2 cycles instr_valid=0, then pc=0x1F0, instr=mem[0x1F0].
- rjmp_off=0xFFE at pc=0x010 -> pc=0x00F. rjmp_off=0x001 at pc=0x1FF -> pc=0x001 (wrap).
- skip at pc=2 with mem[3]=9100 (2-word) -> next valid pc=5. skip at pc=2 with mem[3]=0000 -> next valid pc=4. jmp_req+skip_req together -> jmp wins.
- stall held 3 cycles in RUN -> all outputs frozen, pm_en=0; after release the sequence continues with no lost or duplicated word. RST asserted during a WORD2 cycle -> outputs at reset values immediately.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared definitions for the AVR core: fetch FSM encoding, default PC width and
// the opcode patterns that mark a 32-bit (two-word) instruction.
package avr_pkg;

  localparam int unsigned PC_W_DFLT = 9;

  localparam logic [15:0] NOP = 16'h0000;

  // LDS/STS: fixed top seven bits, low nibble zero.
  localparam logic [15:0] LDS_STS_MASK = 16'hFE0F;
  localparam logic [15:0] LDS_MATCH    = 16'h9000;
  localparam logic [15:0] STS_MATCH    = 16'h9200;
  // JMP/CALL: fixed top seven bits, bits 3:2 set, bit 1 selects JMP vs CALL.
  localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
  localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;

  typedef enum logic [1:0] {
    StFill0,
    StFill1,
    StRun,
    StWord2
  } fetch_state_e;

endpackage

// File: rtl/avr_insn_len.sv
// Flags a 16-bit opcode whose instruction continues into a second word.
module avr_insn_len
  import avr_pkg::*;
(
  input  logic [15:0] i_word,
  output logic        o_is2word
);

  always_comb begin
    o_is2word = ((i_word & LDS_STS_MASK) == LDS_MATCH) ||
                ((i_word & LDS_STS_MASK) == STS_MATCH) ||
                ((i_word & JMP_CALL_MASK) == JMP_CALL_MATCH);
  end

endmodule

// File: rtl/avr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, streams words from a synchronous ROM,
// assembles two-word opcodes and handles jumps/skips with a fixed 2-cycle bubble.
module avr_fetch_ctrl
  import avr_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DFLT,
  parameter int unsigned RST_VEC = 0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_en,
  input  logic [15:0]     pm_data,
  output logic [15:0]     instr,
  output logic [15:0]     op2,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            jmp_req,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            rjmp_req,
  input  logic [11:0]     rjmp_off,
  input  logic            skip_req
);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pm_addr;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_instr;
  logic [15:0]     r_op2;
  logic            r_valid;

  logic            w_data_2w;
  logic            w_instr_2w;
  logic [PC_W-1:0] w_npc;
  logic [PC_W-1:0] w_target;
  logic [31:0]     w_off32;
  logic            w_redirect;
  logic            w_unused_off;

  avr_insn_len u_len_data (
    .i_word    (pm_data),
    .o_is2word (w_data_2w)
  );

  avr_insn_len u_len_instr (
    .i_word    (r_instr),
    .o_is2word (w_instr_2w)
  );

  assign w_npc   = r_pc + (w_instr_2w ? PC_W'(2) : PC_W'(1));
  assign w_off32 = {{20{rjmp_off[11]}}, rjmp_off};
  // Offset bits beyond the PC width vanish under modulo-2^PC_W arithmetic.
  assign w_unused_off = ^w_off32[31:PC_W];

  always_comb begin
    w_target = jmp_target;
    if (!jmp_req) begin
      if (rjmp_req) begin
        w_target = w_npc + w_off32[PC_W-1:0];
      end else begin
        // In RUN the ROM is already presenting mem[npc], so its size is known here.
        w_target = w_npc + PC_W'(1) + {{(PC_W-1){1'b0}}, w_data_2w};
      end
    end
  end

  assign w_redirect = (r_state == StRun) && r_valid && (jmp_req || rjmp_req || skip_req);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= StFill0;
      r_pm_addr <= PC_W'(RST_VEC);
      r_pc      <= PC_W'(RST_VEC);
      r_instr   <= NOP;
      r_op2     <= 16'h0000;
      r_valid   <= 1'b0;
    end else if (!stall) begin
      unique case (r_state)
        StFill0: begin
          r_state   <= StFill1;
          r_pm_addr <= r_pm_addr + PC_W'(1);
        end
        StFill1, StRun: begin
          if (w_redirect) begin
            r_state   <= StFill0;
            r_pm_addr <= w_target;
            r_valid   <= 1'b0;
          end else begin
            r_instr   <= pm_data;
            r_op2     <= 16'h0000;
            // In FILL1 the word on pm_data was fetched from the address before pm_addr.
            r_pc      <= (r_state == StFill1) ? (r_pm_addr - PC_W'(1)) : w_npc;
            r_valid   <= !w_data_2w;
            r_state   <= w_data_2w ? StWord2 : StRun;
            r_pm_addr <= r_pm_addr + PC_W'(1);
          end
        end
        StWord2: begin
          r_op2     <= pm_data;
          r_valid   <= 1'b1;
          r_state   <= StRun;
          r_pm_addr <= r_pm_addr + PC_W'(1);
        end
        default: r_state <= StFill0;
      endcase
    end
  end

  assign pm_en       = !RST && !stall;
  assign pm_addr     = r_pm_addr;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign op2         = r_op2;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_avr_fetch_ctrl.sv
// Directed bench for avr_fetch_ctrl with a behavioural synchronous ROM.
module tb_avr_fetch_ctrl;

  logic        CLK;
  logic        RST;
  logic [8:0]  pm_addr;
  logic        pm_en;
  logic [15:0] pm_data;
  logic [15:0] instr;
  logic [15:0] op2;
  logic        instr_valid;
  logic [8:0]  pc;
  logic        stall;
  logic        jmp_req;
  logic [8:0]  jmp_target;
  logic        rjmp_req;
  logic [11:0] rjmp_off;
  logic        skip_req;

  logic [15:0] mem [512];
  int checks = 0;
  int errors = 0;

  avr_fetch_ctrl #(
    .PC_W    (9),
    .RST_VEC (0)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pm_addr     (pm_addr),
    .pm_en       (pm_en),
    .pm_data     (pm_data),
    .instr       (instr),
    .op2         (op2),
    .instr_valid (instr_valid),
    .pc          (pc),
    .stall       (stall),
    .jmp_req     (jmp_req),
    .jmp_target  (jmp_target),
    .rjmp_req    (rjmp_req),
    .rjmp_off    (rjmp_off),
    .skip_req    (skip_req)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial pm_data = 16'h0000;
  always @(posedge CLK) if (pm_en) pm_data <= mem[pm_addr];

  task automatic do_jmp(input logic [8:0] t);
    jmp_req = 1'b1;
    jmp_target = t;
    @(negedge CLK);
    jmp_req = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if ({pm_addr, pc, instr, op2, instr_valid, pm_en} !== {9'h0, 9'h0, 16'h0, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got %h %h %h %h %b %b exp 000 000 0000 0000 0 0",
               pm_addr, pc, instr, op2, instr_valid, pm_en);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({instr_valid, pm_en} !== 2'b01) begin
      errors++;
      $display("FAIL release_cycle1 valid=%b pm_en=%b exp 0 1", instr_valid, pm_en);
    end
  endtask

  task automatic test_boot();
    @(negedge CLK);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle2 valid=%b exp 0", instr_valid);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr, op2} !== {1'b1, 9'h000, 16'hE0A4, 16'h0}) begin
      errors++;
      $display("FAIL boot_w0 got %b %h %h %h exp 1 000 e0a4 0000", instr_valid, pc, instr, op2);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h001, 16'h50A1}) begin
      errors++;
      $display("FAIL boot_w1 got %b %h %h exp 1 001 50a1", instr_valid, pc, instr);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h002, 16'h0000}) begin
      errors++;
      $display("FAIL boot_w2 got %b %h %h exp 1 002 0000", instr_valid, pc, instr);
    end
  endtask

  task automatic test_2word();
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h003, 16'h0003}) begin
      errors++;
      $display("FAIL seq_w3 got %b %h %h exp 1 003 0003", instr_valid, pc, instr);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b0, 9'h004, 16'h9100}) begin
      errors++;
      $display("FAIL lds_word2_cycle got %b %h %h exp 0 004 9100", instr_valid, pc, instr);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr, op2} !== {1'b1, 9'h004, 16'h9100, 16'h0060}) begin
      errors++;
      $display("FAIL lds_valid got %b %h %h %h exp 1 004 9100 0060", instr_valid, pc, instr, op2);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr, op2} !== {1'b1, 9'h006, 16'h0F01, 16'h0}) begin
      errors++;
      $display("FAIL after_lds got %b %h %h %h exp 1 006 0f01 0000", instr_valid, pc, instr, op2);
    end
  endtask

  task automatic test_jmp();
    jmp_req = 1'b1;
    jmp_target = 9'h1F0;
    @(negedge CLK);
    jmp_req = 1'b0;
    checks++;
    if ({instr_valid, pm_addr} !== {1'b0, 9'h1F0}) begin
      errors++;
      $display("FAIL jmp_bubble1 got %b %h exp 0 1f0", instr_valid, pm_addr);
    end
    @(negedge CLK);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL jmp_bubble2 valid=%b exp 0", instr_valid);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h1F0, 16'hC5A5}) begin
      errors++;
      $display("FAIL jmp_land got %b %h %h exp 1 1f0 c5a5", instr_valid, pc, instr);
    end
  endtask

  task automatic test_stall();
    @(negedge CLK);
    stall = 1'b1;
    #1;
    checks++;
    if (pm_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_pm_en got %b exp 0", pm_en);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({instr_valid, pc, instr, op2, pm_addr} !== {1'b1, 9'h1F1, 16'h01F1, 16'h0, 9'h1F3}) begin
        errors++;
        $display("FAIL stall_hold%0d got %b %h %h %h %h exp 1 1f1 01f1 0000 1f3",
                 i, instr_valid, pc, instr, op2, pm_addr);
      end
    end
    stall = 1'b0;
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h1F2, 16'h01F2}) begin
      errors++;
      $display("FAIL stall_resume1 got %b %h %h exp 1 1f2 01f2", instr_valid, pc, instr);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h1F3, 16'h01F3}) begin
      errors++;
      $display("FAIL stall_resume2 got %b %h %h exp 1 1f3 01f3", instr_valid, pc, instr);
    end
  endtask

  task automatic test_rjmp();
    repeat (12) @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr, pm_addr} !== {1'b1, 9'h1FF, 16'h01FF, 9'h001}) begin
      errors++;
      $display("FAIL pc_top got %b %h %h %h exp 1 1ff 01ff 001", instr_valid, pc, instr, pm_addr);
    end
    rjmp_req = 1'b1;
    rjmp_off = 12'h001;
    @(negedge CLK);
    rjmp_req = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h001, 16'h50A1}) begin
      errors++;
      $display("FAIL rjmp_wrap got %b %h %h exp 1 001 50a1", instr_valid, pc, instr);
    end
    do_jmp(9'h010);
    rjmp_req = 1'b1;
    rjmp_off = 12'hFFE;
    @(negedge CLK);
    rjmp_req = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h00F, 16'h000F}) begin
      errors++;
      $display("FAIL rjmp_back got %b %h %h exp 1 00f 000f", instr_valid, pc, instr);
    end
  endtask

  task automatic test_skip();
    mem[3] = 16'h9100;
    do_jmp(9'h002);
    skip_req = 1'b1;
    @(negedge CLK);
    skip_req = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h005, 16'h0060}) begin
      errors++;
      $display("FAIL skip_2word got %b %h %h exp 1 005 0060", instr_valid, pc, instr);
    end
    mem[3] = 16'h0000;
    do_jmp(9'h002);
    skip_req = 1'b1;
    @(negedge CLK);
    skip_req = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr, op2} !== {1'b1, 9'h004, 16'h9100, 16'h0060}) begin
      errors++;
      $display("FAIL skip_1word got %b %h %h %h exp 1 004 9100 0060", instr_valid, pc, instr, op2);
    end
  endtask

  task automatic test_priority();
    jmp_req = 1'b1;
    jmp_target = 9'h020;
    skip_req = 1'b1;
    @(negedge CLK);
    jmp_req = 1'b0;
    skip_req = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h020, 16'h0020}) begin
      errors++;
      $display("FAIL jmp_over_skip got %b %h %h exp 1 020 0020", instr_valid, pc, instr);
    end
    rjmp_req = 1'b1;
    rjmp_off = 12'h010;
    skip_req = 1'b1;
    @(negedge CLK);
    rjmp_req = 1'b0;
    skip_req = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 9'h031, 16'h0031}) begin
      errors++;
      $display("FAIL rjmp_over_skip got %b %h %h exp 1 031 0031", instr_valid, pc, instr);
    end
  endtask

  task automatic test_rst_word2();
    do_jmp(9'h004);
    checks++;
    if ({instr_valid, pc, instr} !== {1'b0, 9'h004, 16'h9100}) begin
      errors++;
      $display("FAIL pre_rst_word2 got %b %h %h exp 0 004 9100", instr_valid, pc, instr);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({pm_addr, pc, instr, op2, instr_valid, pm_en} !== {9'h0, 9'h0, 16'h0, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL rst_in_word2 got %h %h %h %h %b %b exp 000 000 0000 0000 0 0",
               pm_addr, pc, instr, op2, instr_valid, pm_en);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reboot_cycle2 valid=%b exp 0", instr_valid);
    end
    @(negedge CLK);
    checks++;
    if ({instr_valid, pc, instr, op2} !== {1'b1, 9'h000, 16'hE0A4, 16'h0}) begin
      errors++;
      $display("FAIL reboot_w0 got %b %h %h %h exp 1 000 e0a4 0000", instr_valid, pc, instr, op2);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i);
    mem[0] = 16'hE0A4;
    mem[1] = 16'h50A1;
    mem[2] = 16'h0000;
    mem[4] = 16'h9100;
    mem[5] = 16'h0060;
    mem[6] = 16'h0F01;
    mem[9'h1F0] = 16'hC5A5;
    RST = 1'b1;
    stall = 1'b0;
    jmp_req = 1'b0;
    jmp_target = 9'h0;
    rjmp_req = 1'b0;
    rjmp_off = 12'h0;
    skip_req = 1'b0;

    test_reset();
    test_boot();
    test_2word();
    test_jmp();
    test_stall();
    test_rjmp();
    test_skip();
    test_priority();
    test_rst_word2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
